hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard unit for the in-order pipeline. It tracks per-register result-ready countdowns, so the block handles variable-latency producers (ALU, load, multi-cycle mul/div) without hard-coded stage compares. It drives decode/fetch stalls, branch flushes and exec-stage forwarding selects. It sits beside the decode/exec pipeline registers and replaces the purely combinational Exec/Mem address-compare stall logic.

## Interface
Parameters:
- NUM_SRC, 2: source operands per instruction (2 or 3).
- REG_AW, 5: register address width; number of registers is 2**REG_AW.
- LOAD_LAT, 1: cycles after issue before a load result is forwardable.
- MULDIV_LAT, 4: cycles after issue before a mul/div result is forwardable. Range 2..15.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- dec_valid_i  in  1  decode holds a valid instruction.
- src_addr_dec_i  in  NUM_SRC*REG_AW  decode source addresses.
- src_used_dec_i  in  NUM_SRC  per-source "operand is read" flag.
- dst_addr_dec_i  in  REG_AW  decode destination.
- dst_wr_dec_i  in  1  decode instruction writes a register.
- op_class_dec_i  in  2  producer class of the decode instruction: 0 = ALU, 1 = LOAD, 2 = MULDIV.
- src_addr_exec_i  in  NUM_SRC*REG_AW  exec-stage source addresses.
- dst_addr_mem_i, dst_addr_wb_i  in  REG_AW  each: destinations in the mem and wb stages.
- reg_wr_mem_i, reg_wr_wb_i  in  1  each: write enables in the mem and wb stages.
- branch_taken_exec_i  in  1  taken branch/jump resolved in exec.
- stall_fetch_o, stall_decode_o  out  1  each: hold the fetch and decode registers.
- flush_decode_o, flush_exec_o  out  1  each: bubble the decode and exec registers.
- fwd_sel_exec_o  out  NUM_SRC*2  per-source select: 0 = RF, 1 = WB, 2 = MEM.
- muldiv_busy_o  out  1  mul/div unit is occupied.

## Operation
- Scoreboard: one counter cnt[r] per register, wide enough to hold MULDIV_LAT+2. Register 0 is never written; cnt[0] is always 0.
- Issue condition: issue = dec_valid_i & ~stall_decode_o & ~branch_taken_exec_i.
- On issue with dst_wr_dec_i and dst != 0, cnt[dst] loads the class latency: ALU 0, LOAD LOAD_LAT, MULDIV MULDIV_LAT.
- Every other nonzero counter decrements by 1 each cycle. On the issue cycle, the load takes priority over the decrement of that entry.
- RAW stall: any source with src_used set, address != 0 and cnt[src] != 0.
- WAW stall: dst_wr_dec_i and cnt[dst] > latency of the decode instruction's own class. This keeps writes in order.
- Structural stall: op_class_dec_i == MULDIV while muldiv_busy_o is set.
- muldiv_busy_o: a busy counter loads MULDIV_LAT-1 when a MULDIV issues and decrements to 0; busy is asserted while the counter is nonzero.
- stall_fetch_o = stall_decode_o = dec_valid_i & (RAW | WAW | structural). When no valid instruction is in decode, no stall is raised.
- Flush: flush_decode_o = flush_exec_o = branch_taken_exec_i, and it overrides stall.
- A flushed decode instruction never issues, so it is never recorded in the scoreboard. Older in-flight entries keep counting.
- Forwarding, evaluated per exec source:
  - address == 0 selects RF.
  - otherwise MEM if reg_wr_mem_i and dst_addr_mem_i matches;
  - otherwise WB if reg_wr_wb_i and dst_addr_wb_i matches;
  - otherwise RF.
  - MEM has priority over WB.

## Timing
- All outputs are combinational from the scoreboard state and the current inputs; there is zero-cycle latency from inputs to stall, flush and fwd outputs.
- Scoreboard and busy state update on the rising edge of clk_i.
- Reset state: all counters 0 and busy 0. With dec_valid_i=0 and branch_taken_exec_i=0, every output is 0.
- Reset asserted mid-operation clears all pending entries immediately. The pipeline must be flushed by its own reset.
- A consumer issued k cycles after a producer proceeds when k > latency. For example, a load followed immediately by a dependent instruction stalls exactly LOAD_LAT cycles.
- When branch_taken_exec_i and a stall condition occur in the same cycle, flush wins and no stall is asserted.

## Configuration
- HAZARD_FWD_EN defined:
  - forwarding is active;
  - latencies are as listed above.
- HAZARD_FWD_EN undefined:
  - fwd_sel_exec_o is tied to 0;
  - every class latency is increased by 2, so consumers wait until the producer's WB write. The RF is write-first.

## Structure
- hazard_pkg holds:
  - op_class_e (ALU/LOAD/MULDIV) and fwd_sel_e (RF/WB/MEM);
  - the latency offset constant FWD_PENALTY = 2;
  - a function returning the class latency.
- Sub-module hazard_fwd_sel, instantiated NUM_SRC times, computes one source's forwarding select.

## Test plan
- Reset check: reset, then dec_valid_i=1 with sources x1/x2 and an empty scoreboard -> no stall; all fwd_sel = 0.
- Load-use: LOAD to x5 issues, next decode reads x5 -> stall for exactly 1 cycle (LOAD_LAT=1), then issue. With the instruction in exec, and mem matching x5, fwd_sel = 2.
- Mul/div RAW plus structural: MULDIV to x7, then ADD reading x7 -> 4 stall cycles. A second MULDIV issued back-to-back stalls until muldiv_busy_o falls after 3 cycles.
- WAW: MULDIV to x9, then ALU writing x9 -> stall until cnt[9] == 0. The ALU then issues and cnt[9] stays 0.
- Flush priority: branch_taken_exec_i together with a load-use stall -> flush outputs 1, stall outputs 0, and no scoreboard entry for the decode destination.
- Forward priority: mem and wb both writing x3 while exec reads x3 -> fwd_sel = 2. A source address of 0 while mem writes x0 -> fwd_sel = 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and latency helper for the hazard scoreboard.
// HAZARD_FWD_EN selects forwarding; when undefined, latencies include the WB penalty.
package hazard_pkg;

    typedef enum logic [1:0] {
        OP_ALU    = 2'd0,
        OP_LOAD   = 2'd1,
        OP_MULDIV = 2'd2
    } op_class_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_e;

    localparam int unsigned FWD_PENALTY = 2;

`ifdef HAZARD_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    // Without forwarding a consumer must wait for the producer's WB write.
    function automatic int unsigned class_lat(input logic [1:0] cls,
                                              input int unsigned load_lat,
                                              input int unsigned muldiv_lat);
        int unsigned lat;
        case (cls)
            OP_LOAD:   lat = load_lat;
            OP_MULDIV: lat = muldiv_lat;
            default:   lat = 0;
        endcase
        if (!FWD_EN) begin
            lat = lat + FWD_PENALTY;
        end
        return lat;
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one exec-stage source operand; MEM has priority over WB.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_addr_i,
    input  logic [REG_AW-1:0] dst_addr_mem_i,
    input  logic              reg_wr_mem_i,
    input  logic [REG_AW-1:0] dst_addr_wb_i,
    input  logic              reg_wr_wb_i,
    output logic [1:0]        sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (src_addr_i != '0) begin
            if (reg_wr_mem_i && (dst_addr_mem_i == src_addr_i)) begin
                sel_o = FWD_MEM;
            end else if (reg_wr_wb_i && (dst_addr_wb_i == src_addr_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register result-ready countdown scoreboard driving stalls, flushes and forwarding.
// Build option HAZARD_FWD_EN (see hazard_pkg) enables exec-stage forwarding.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned MULDIV_LAT = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      dec_valid_i,
    input  logic [NUM_SRC*REG_AW-1:0] src_addr_dec_i,
    input  logic [NUM_SRC-1:0]        src_used_dec_i,
    input  logic [REG_AW-1:0]         dst_addr_dec_i,
    input  logic                      dst_wr_dec_i,
    input  logic [1:0]                op_class_dec_i,
    input  logic [NUM_SRC*REG_AW-1:0] src_addr_exec_i,
    input  logic [REG_AW-1:0]         dst_addr_mem_i,
    input  logic [REG_AW-1:0]         dst_addr_wb_i,
    input  logic                      reg_wr_mem_i,
    input  logic                      reg_wr_wb_i,
    input  logic                      branch_taken_exec_i,
    output logic                      stall_fetch_o,
    output logic                      stall_decode_o,
    output logic                      flush_decode_o,
    output logic                      flush_exec_o,
    output logic [NUM_SRC*2-1:0]      fwd_sel_exec_o,
    output logic                      muldiv_busy_o
);

    localparam int unsigned NREG  = 2 ** REG_AW;
    localparam int unsigned CNT_W = $clog2(MULDIV_LAT + FWD_PENALTY + 1);

    logic [CNT_W-1:0]  cnt_q [NREG];
    logic [CNT_W-1:0]  cnt_d [NREG];
    logic [CNT_W-1:0]  busy_q;
    logic [CNT_W-1:0]  busy_d;

    logic [CNT_W-1:0]  lat_dec;
    logic [REG_AW-1:0] raw_src;
    logic              raw_haz;
    logic              waw_haz;
    logic              struct_haz;
    logic              hazard;
    logic              issue;
    logic              stall;
    logic [NUM_SRC*2-1:0] fwd_sel_w;

    assign lat_dec = CNT_W'(class_lat(op_class_dec_i, LOAD_LAT, MULDIV_LAT));

    always_comb begin
        raw_haz = 1'b0;
        raw_src = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            raw_src = src_addr_dec_i[i*REG_AW +: REG_AW];
            if (src_used_dec_i[i] && (raw_src != '0) && (cnt_q[raw_src] != '0)) begin
                raw_haz = 1'b1;
            end
        end
    end

    // A pending write that outlives this instruction's own latency would retire out of order.
    assign waw_haz    = dst_wr_dec_i && (cnt_q[dst_addr_dec_i] > lat_dec);
    assign struct_haz = (op_class_dec_i == OP_MULDIV) && (busy_q != '0);
    assign hazard     = raw_haz || waw_haz || struct_haz;

    assign stall = dec_valid_i && hazard && !branch_taken_exec_i;
    assign issue = dec_valid_i && !hazard && !branch_taken_exec_i;

    always_comb begin
        cnt_d[0] = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? (cnt_q[r] - CNT_W'(1)) : '0;
            if (issue && dst_wr_dec_i && (dst_addr_dec_i == REG_AW'(r))) begin
                cnt_d[r] = lat_dec;
            end
        end
    end

    always_comb begin
        busy_d = (busy_q != '0) ? (busy_q - CNT_W'(1)) : '0;
        if (issue && (op_class_dec_i == OP_MULDIV)) begin
            busy_d = CNT_W'(MULDIV_LAT - 1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            busy_q <= busy_d;
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
        hazard_fwd_sel #(
            .REG_AW(REG_AW)
        ) u_fwd_sel (
            .src_addr_i     (src_addr_exec_i[g*REG_AW +: REG_AW]),
            .dst_addr_mem_i (dst_addr_mem_i),
            .reg_wr_mem_i   (reg_wr_mem_i),
            .dst_addr_wb_i  (dst_addr_wb_i),
            .reg_wr_wb_i    (reg_wr_wb_i),
            .sel_o          (fwd_sel_w[g*2 +: 2])
        );
    end

    assign fwd_sel_exec_o = FWD_EN ? fwd_sel_w : '0;
    assign stall_fetch_o  = stall;
    assign stall_decode_o = stall;
    assign flush_decode_o = branch_taken_exec_i;
    assign flush_exec_o   = branch_taken_exec_i;
    assign muldiv_busy_o  = (busy_q != '0);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard against a ready-time reference model.
module tb_hazard_scoreboard;

    localparam int unsigned NUM_SRC    = 2;
    localparam int unsigned REG_AW     = 5;
    localparam int unsigned LOAD_LAT   = 1;
    localparam int unsigned MULDIV_LAT = 4;
`ifdef HAZARD_FWD_EN
    localparam int PEN = 0;
    localparam bit FWD = 1'b1;
`else
    localparam int PEN = 2;
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic                      dec_valid;
    logic [NUM_SRC*REG_AW-1:0] src_dec;
    logic [NUM_SRC-1:0]        used_dec;
    logic [REG_AW-1:0]         dst_dec;
    logic                      wr_dec;
    logic [1:0]                cls_dec;
    logic [NUM_SRC*REG_AW-1:0] src_exec;
    logic [REG_AW-1:0]         dst_mem, dst_wb;
    logic                      wr_mem, wr_wb, br;
    logic                      stall_f, stall_d, flush_d, flush_e, busy;
    logic [NUM_SRC*2-1:0]      fwd_sel;

    hazard_scoreboard #(
        .NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .MULDIV_LAT(MULDIV_LAT)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .dec_valid_i(dec_valid), .src_addr_dec_i(src_dec), .src_used_dec_i(used_dec),
        .dst_addr_dec_i(dst_dec), .dst_wr_dec_i(wr_dec), .op_class_dec_i(cls_dec),
        .src_addr_exec_i(src_exec), .dst_addr_mem_i(dst_mem), .dst_addr_wb_i(dst_wb),
        .reg_wr_mem_i(wr_mem), .reg_wr_wb_i(wr_wb), .branch_taken_exec_i(br),
        .stall_fetch_o(stall_f), .stall_decode_o(stall_d),
        .flush_decode_o(flush_d), .flush_exec_o(flush_e),
        .fwd_sel_exec_o(fwd_sel), .muldiv_busy_o(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int ready_at [2**REG_AW];   // first cycle in which a register's result is consumable
    int busy_free = 0;          // first cycle in which the mul/div unit is free
    bit dut_stall;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input logic [1:0] c);
        case (c)
            2'd1:    return LOAD_LAT + PEN;
            2'd2:    return MULDIV_LAT + PEN;
            default: return PEN;
        endcase
    endfunction

    task automatic set_dec(input bit v, input int s0, input int s1, input logic [1:0] u,
                           input int d, input bit w, input logic [1:0] c);
        dec_valid = v;
        src_dec   = {REG_AW'(s1), REG_AW'(s0)};
        used_dec  = u;
        dst_dec   = REG_AW'(d);
        wr_dec    = w;
        cls_dec   = c;
        src_exec  = '0;
        dst_mem   = '0;
        dst_wb    = '0;
        wr_mem    = 1'b0;
        wr_wb     = 1'b0;
        br        = 1'b0;
    endtask

    task automatic step(input string tag);
        bit raw, waw, strc, exp_stall, exp_issue;
        int a;
        logic [NUM_SRC*2-1:0] fexp;
        #1;
        raw = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            a = int'(src_dec[i*REG_AW +: REG_AW]);
            if (used_dec[i] && a != 0 && ready_at[a] > cyc) raw = 1;
        end
        waw  = wr_dec && dst_dec != 0 && (ready_at[dst_dec] - cyc > lat_of(cls_dec));
        strc = (cls_dec == 2'd2) && (cyc < busy_free);
        exp_stall = dec_valid && !br && (raw || waw || strc);
        exp_issue = dec_valid && !br && !(raw || waw || strc);
        fexp = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            a = int'(src_exec[i*REG_AW +: REG_AW]);
            if (FWD && a != 0) begin
                if (wr_mem && int'(dst_mem) == a)     fexp[i*2 +: 2] = 2'd2;
                else if (wr_wb && int'(dst_wb) == a) fexp[i*2 +: 2] = 2'd1;
            end
        end
        check_val({tag, ".stall_f"}, 32'(stall_f), 32'(exp_stall));
        check_val({tag, ".stall_d"}, 32'(stall_d), 32'(exp_stall));
        check_val({tag, ".flush_d"}, 32'(flush_d), 32'(br));
        check_val({tag, ".flush_e"}, 32'(flush_e), 32'(br));
        check_val({tag, ".fwd"},     32'(fwd_sel), 32'(fexp));
        check_val({tag, ".busy"},    32'(busy),    32'(cyc < busy_free));
        dut_stall = stall_d;
        if (exp_issue) begin
            if (wr_dec && dst_dec != 0) ready_at[dst_dec] = cyc + lat_of(cls_dec) + 1;
            if (cls_dec == 2'd2) busy_free = cyc + int'(MULDIV_LAT);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        set_dec(0, 0, 0, 2'b00, 0, 0, 2'd0);
        rst_n = 1'b0;
        #1;
        check_val("rst.stall_f", 32'(stall_f), 0);
        check_val("rst.stall_d", 32'(stall_d), 0);
        check_val("rst.flush",   32'({flush_d, flush_e}), 0);
        check_val("rst.fwd",     32'(fwd_sel), 0);
        check_val("rst.busy",    32'(busy), 0);
        foreach (ready_at[r]) ready_at[r] = 0;
        busy_free = 0;
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        @(negedge clk);
        cyc++;
    endtask

    // Drives a consumer until it issues and returns the number of stalled cycles.
    task automatic count_stalls(input string tag, output int n);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            step(tag);
            if (!dut_stall) break;
            n++;
        end
    endtask

    initial begin
        int n;
        set_dec(0, 0, 0, 2'b00, 0, 0, 2'd0);
        foreach (ready_at[r]) ready_at[r] = 0;
        @(negedge clk);
        do_reset();

        set_dec(1, 1, 2, 2'b11, 0, 0, 2'd0);
        step("rst_dec");

        // load-use, then exec-stage MEM forward of x5
        set_dec(1, 0, 0, 2'b00, 5, 1, 2'd1);
        step("ld_issue");
        set_dec(1, 5, 0, 2'b01, 6, 1, 2'd0);
        count_stalls("ld_use", n);
        check_val("ld_use_len", 32'(n), 32'(LOAD_LAT + PEN));
        set_dec(0, 0, 0, 2'b00, 0, 0, 2'd0);
        src_exec = {REG_AW'(0), REG_AW'(5)};
        dst_mem = 5; wr_mem = 1'b1;
        step("ld_fwd");

        // mul/div RAW
        do_reset();
        set_dec(1, 0, 0, 2'b00, 7, 1, 2'd2);
        step("md_issue");
        set_dec(1, 7, 0, 2'b01, 8, 1, 2'd0);
        count_stalls("md_raw", n);
        check_val("md_raw_len", 32'(n), 32'(MULDIV_LAT + PEN));

        // mul/div structural
        do_reset();
        set_dec(1, 0, 0, 2'b00, 10, 1, 2'd2);
        step("md2_issue");
        set_dec(1, 0, 0, 2'b00, 11, 1, 2'd2);
        count_stalls("md_struct", n);
        check_val("md_struct_len", 32'(n), 32'(MULDIV_LAT - 1));

        // WAW
        do_reset();
        set_dec(1, 0, 0, 2'b00, 9, 1, 2'd2);
        step("waw_md");
        set_dec(1, 0, 0, 2'b00, 9, 1, 2'd0);
        count_stalls("waw_alu", n);
        check_val("waw_len", 32'(n), 32'(MULDIV_LAT));
        set_dec(1, 9, 0, 2'b01, 0, 0, 2'd0);
        step("waw_after");

        // flush beats load-use stall, flushed destination not recorded
        do_reset();
        set_dec(1, 0, 0, 2'b00, 5, 1, 2'd1);
        step("fl_ld");
        set_dec(1, 5, 0, 2'b01, 12, 1, 2'd2);
        br = 1'b1;
        step("fl_br");
        set_dec(1, 12, 0, 2'b01, 0, 0, 2'd0);
        step("fl_after");

        // forward priority and x0
        set_dec(0, 0, 0, 2'b00, 0, 0, 2'd0);
        src_exec = {REG_AW'(0), REG_AW'(3)};
        dst_mem = 3; wr_mem = 1'b1; dst_wb = 3; wr_wb = 1'b1;
        step("fwd_prio");
        src_exec = {REG_AW'(3), REG_AW'(0)};
        dst_mem = 0; wr_mem = 1'b1; dst_wb = 3; wr_wb = 1'b1;
        step("fwd_x0");

        // randomized traffic over a small register window
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                dec_valid = ($urandom_range(0, 9) < 8);
                src_dec   = {REG_AW'($urandom_range(0, 7)), REG_AW'($urandom_range(0, 7))};
                used_dec  = NUM_SRC'($urandom);
                dst_dec   = REG_AW'($urandom_range(0, 7));
                wr_dec    = ($urandom_range(0, 3) != 0);
                cls_dec   = 2'($urandom_range(0, 2));
                src_exec  = {REG_AW'($urandom_range(0, 7)), REG_AW'($urandom_range(0, 7))};
                dst_mem   = REG_AW'($urandom_range(0, 7));
                dst_wb    = REG_AW'($urandom_range(0, 7));
                wr_mem    = 1'($urandom);
                wr_wb     = 1'($urandom);
                br        = ($urandom_range(0, 9) == 0);
                step("rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
